// File: rtl/sobel_window_gen_pkg.sv
// Shared types for the Sobel 3x3 window generator: pixel/window types and
// the frame-sequencing FSM state encoding.
package sobel_pkg;

  localparam int unsigned PIX_W = 8;

  typedef logic [PIX_W-1:0] pixel_t;

  // [row][col]; [2][2] is the newest pixel, [0][0] the oldest
  typedef pixel_t [2:0][2:0] window_t;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/sobel_window_gen_if.sv
// Pixel stream in / window out bundle for sobel_window_gen.
// The frame_done signal exists only when SOBEL_WIN_FRAME_DONE_EN is defined.
interface sobel_window_gen_if;
  import sobel_pkg::*;

  logic    frame_start;
  logic    pixel_valid;
  pixel_t  pixel_in;
  window_t comp_matrix;
  logic    sobel_en;
  logic    busy;
`ifdef SOBEL_WIN_FRAME_DONE_EN
  logic    frame_done;

  modport master (
    output frame_start, pixel_valid, pixel_in,
    input  comp_matrix, sobel_en, busy, frame_done
  );

  modport slave (
    input  frame_start, pixel_valid, pixel_in,
    output comp_matrix, sobel_en, busy, frame_done
  );
`else
  modport master (
    output frame_start, pixel_valid, pixel_in,
    input  comp_matrix, sobel_en, busy
  );

  modport slave (
    input  frame_start, pixel_valid, pixel_in,
    output comp_matrix, sobel_en, busy
  );
`endif

endinterface

// File: rtl/sobel_window_gen_line_buffer.sv
// Two-row line buffer: per column it holds the pixel from one row up
// (lb_prev) and two rows up (lb_old). A write at a column pushes the new
// pixel into lb_prev and ages the previous lb_prev into lb_old.
// Storage is deliberately not reset.
module sobel_line_buffer
  import sobel_pkg::*;
#(
  parameter  int unsigned IMG_WIDTH = 16,
  localparam int unsigned ADDR_W    = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] addr,
  input  pixel_t            wr_data,
  output pixel_t            rd_old,
  output pixel_t            rd_prev
);

  pixel_t lb_old  [IMG_WIDTH];
  pixel_t lb_prev [IMG_WIDTH];

  // Asynchronous read of both rows at the current column
  always_comb begin
    rd_old  = lb_old[addr];
    rd_prev = lb_prev[addr];
  end

  // Shift the column's history down by one row on every accepted pixel
  always_ff @(posedge clk) begin
    if (wr_en) begin
      lb_old[addr]  <= lb_prev[addr];
      lb_prev[addr] <= wr_data;
    end
  end

endmodule

// File: rtl/sobel_window_gen.sv
// Sobel 3x3 window generator: turns a raster pixel stream into sliding
// 3x3 windows and flags the interior (complete) ones with sobel_en.
// Optional feature: define SOBEL_WIN_FRAME_DONE_EN to add frame_done.
module sobel_window_gen
  import sobel_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = 16,
  parameter int unsigned IMG_HEIGHT = 16
) (
  input logic               clk,
  input logic               rst,
  sobel_window_gen_if.slave bus
);

  localparam int unsigned COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int unsigned ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  state_t           state_q;
  state_t           state_d;
  logic [COL_W-1:0] col_q;
  logic [ROW_W-1:0] row_q;
  logic [COL_W-1:0] acc_col;
  logic [ROW_W-1:0] acc_row;
  logic             accept;
  logic             last_col;
  logic             last_row;
  logic             interior;
  pixel_t           rd_old;
  pixel_t           rd_prev;
  pixel_t           top_px;
  pixel_t           mid_px;

  // Acceptance and the effective (row, col) of the pixel being accepted;
  // a pixel arriving with frame_start is always (0, 0) of the new frame.
  // Line-buffer rows not yet written in this frame are masked to zero so
  // stale storage never reaches comp_matrix.
  always_comb begin
    accept   = bus.pixel_valid &&
               (bus.frame_start || (state_q == FILL) || (state_q == RUN));
    acc_col  = bus.frame_start ? '0 : col_q;
    acc_row  = bus.frame_start ? '0 : row_q;
    last_col = (acc_col == COL_W'(IMG_WIDTH - 1));
    last_row = (acc_row == ROW_W'(IMG_HEIGHT - 1));
    interior = (acc_row >= ROW_W'(2)) && (acc_col >= COL_W'(2));
    top_px   = (acc_row >= ROW_W'(2)) ? rd_old  : '0;
    mid_px   = (acc_row >= ROW_W'(1)) ? rd_prev : '0;
  end

  sobel_line_buffer #(
    .IMG_WIDTH (IMG_WIDTH)
  ) u_line_buffer (
    .clk     (clk),
    .wr_en   (accept),
    .addr    (acc_col),
    .wr_data (bus.pixel_in),
    .rd_old  (rd_old),
    .rd_prev (rd_prev)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state and state-decoded outputs
  always_comb begin
    state_d  = state_q;
    bus.busy = (state_q == FILL) || (state_q == RUN);
`ifdef SOBEL_WIN_FRAME_DONE_EN
    bus.frame_done = (state_q == DONE);
`endif
    if (bus.frame_start) begin
      state_d = FILL;
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        FILL: if (accept && last_col && (acc_row == ROW_W'(1))) state_d = RUN;
        RUN:  if (accept && last_col && last_row) state_d = DONE;
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Raster position counters; frame_start restarts them from (0, 0)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
    end else if (accept) begin
      if (last_col) begin
        col_q <= '0;
        row_q <= acc_row + ROW_W'(1);
      end else begin
        col_q <= acc_col + COL_W'(1);
        row_q <= acc_row;
      end
    end else if (bus.frame_start) begin
      col_q <= '0;
      row_q <= '0;
    end
  end

  // Window shift register and the interior-window strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.comp_matrix <= '0;
      bus.sobel_en    <= 1'b0;
    end else begin
      bus.sobel_en <= accept && interior;
      if (accept) begin
        for (int unsigned r = 0; r < 3; r++) begin
          bus.comp_matrix[r][0] <= bus.comp_matrix[r][1];
          bus.comp_matrix[r][1] <= bus.comp_matrix[r][2];
        end
        bus.comp_matrix[0][2] <= top_px;
        bus.comp_matrix[1][2] <= mid_px;
        bus.comp_matrix[2][2] <= bus.pixel_in;
      end
    end
  end

endmodule

// File: tb/tb_sobel_window_gen.sv
// Testbench for sobel_window_gen: a 4x4 instance for directed and table
// cases, a default 16x16 instance for a random frame. Expected windows come
// from a frame image array sliced directly into 3x3 neighbourhoods.
module tb_sobel_window_gen;
  import sobel_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sobel_window_gen_if bus4 ();
  sobel_window_gen_if bus16 ();

  sobel_window_gen #(.IMG_WIDTH(4), .IMG_HEIGHT(4)) dut4 (
    .clk (clk), .rst (rst), .bus (bus4.slave)
  );

  sobel_window_gen dut16 (
    .clk (clk), .rst (rst), .bus (bus16.slave)
  );

  int checks   = 0;
  int failures = 0;
  int fd_cnt   = 0;

  window_t got4  [$];
  window_t got16 [$];
  window_t exp_q [$];
  pixel_t  img   [16][16];

  typedef struct {
    int     gap;
    int     base;
    int     exp_pulses;
    pixel_t exp_first_center;
  } vec_t;

  vec_t tbl [4];

  // Collect every window presented with sobel_en, away from the clock edge
  always @(negedge clk) begin
    if (bus4.sobel_en)  got4.push_back(bus4.comp_matrix);
    if (bus16.sobel_en) got16.push_back(bus16.comp_matrix);
`ifdef SOBEL_WIN_FRAME_DONE_EN
    if (bus16.frame_done) fd_cnt++;
`endif
  end

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus4.frame_start  = 1'b0;
    bus4.pixel_valid  = 1'b0;
    bus4.pixel_in     = '0;
    bus16.frame_start = 1'b0;
    bus16.pixel_valid = 1'b0;
    bus16.pixel_in    = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One valid pixel followed by `gap` idle cycles
  task automatic send(input bit big, input logic fs, input pixel_t v, input int gap);
    if (big) begin
      bus16.frame_start = fs; bus16.pixel_valid = 1'b1; bus16.pixel_in = v;
    end else begin
      bus4.frame_start = fs; bus4.pixel_valid = 1'b1; bus4.pixel_in = v;
    end
    tick();
    idle_inputs();
    repeat (gap) tick();
  endtask

  // Every interior position (r, c) yields the 3x3 neighbourhood ending there
  function automatic void build_expected(input int w, input int h);
    window_t win;
    exp_q.delete();
    for (int r = 2; r < h; r++)
      for (int c = 2; c < w; c++) begin
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            win[i][j] = img[r-2+i][c-2+j];
        exp_q.push_back(win);
      end
  endfunction

  task automatic compare_windows(input string name, input bit big);
    window_t g [$];
    int n;
    if (big) g = got16; else g = got4;
    check($sformatf("%s_count", name), 72'(g.size()), 72'(exp_q.size()));
    n = (g.size() < exp_q.size()) ? g.size() : exp_q.size();
    for (int k = 0; k < n; k++)
      check($sformatf("%s_win%0d", name, k), g[k], exp_q[k]);
  endtask

  task automatic frame4(input int base, input int gap);
    got4.delete();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        img[r][c] = pixel_t'(base + r * 4 + c);
    build_expected(4, 4);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        send(1'b0, (r == 0 && c == 0), img[r][c], gap);
    repeat (3) tick();
  endtask

  initial begin
    window_t first;
    window_t w028;
    int      gap;

    tbl[0] = '{gap: 0, base: 0,   exp_pulses: 4, exp_first_center: 8'd5};
    tbl[1] = '{gap: 1, base: 0,   exp_pulses: 4, exp_first_center: 8'd5};
    tbl[2] = '{gap: 2, base: 100, exp_pulses: 4, exp_first_center: 8'd105};
    tbl[3] = '{gap: 0, base: 250, exp_pulses: 4, exp_first_center: 8'd255};

    w028 = '{'{8'd10, 8'd9, 8'd8}, '{8'd6, 8'd5, 8'd4}, '{8'd2, 8'd1, 8'd0}};

    // Reset state
    idle_inputs();
    rst = 1'b1;
    #2;
    check("rst_matrix4", bus4.comp_matrix, '0);
    check("rst_sobel_en4", 72'(bus4.sobel_en), 72'(0));
    check("rst_busy4", 72'(bus4.busy), 72'(0));
    check("rst_busy16", 72'(bus16.busy), 72'(0));
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // 4x4 ramp frame, continuous valid: first window literal
    frame4(0, 0);
    first = (got4.size() > 0) ? got4[0] : '0;
    check("ramp_first_window", first, w028);
    compare_windows("ramp", 1'b0);
    check("ramp_busy_after", 72'(bus4.busy), 72'(0));

    // Table: gap patterns and bases (including byte wrap)
    for (int i = 0; i < 4; i++) begin
      frame4(tbl[i].base, tbl[i].gap);
      first = (got4.size() > 0) ? got4[0] : '0;
      check($sformatf("tbl%0d_pulses", i), 72'(got4.size()), 72'(tbl[i].exp_pulses));
      check($sformatf("tbl%0d_center", i), 72'(first[1][1]), 72'(tbl[i].exp_first_center));
      compare_windows($sformatf("tbl%0d", i), 1'b0);
      check($sformatf("tbl%0d_hold", i), bus4.comp_matrix, exp_q[exp_q.size()-1]);
      check($sformatf("tbl%0d_idle", i), 72'(bus4.busy), 72'(0));
    end

    // Restart from RUN: frame_start with a valid pixel makes it (0,0)
    got4.delete();
    for (int k = 0; k < 9; k++) send(1'b0, (k == 0), pixel_t'(200 + k), 0);
    check("restart_busy_run", 72'(bus4.busy), 72'(1));
    check("restart_no_pulse_yet", 72'(got4.size()), 72'(0));
    frame4(50, 0);
    compare_windows("restart", 1'b0);

    // Reset after the 7th pixel
    got4.delete();
    for (int k = 0; k < 7; k++) send(1'b0, (k == 0), pixel_t'(1 + k), 0);
    check("midrst_busy_before", 72'(bus4.busy), 72'(1));
    check("midrst_matrix_nonzero", 72'(bus4.comp_matrix != '0), 72'(1));
    rst = 1'b1;
    #1;
    check("midrst_matrix", bus4.comp_matrix, '0);
    check("midrst_sobel_en", 72'(bus4.sobel_en), 72'(0));
    check("midrst_busy", 72'(bus4.busy), 72'(0));
    tick();
    rst = 1'b0;
    for (int k = 0; k < 20; k++) send(1'b0, 1'b0, pixel_t'(k + 40), 0);
    check("postrst_ignored_busy", 72'(bus4.busy), 72'(0));
    check("postrst_ignored_pulses", 72'(got4.size()), 72'(0));
    check("postrst_ignored_matrix", bus4.comp_matrix, '0);
    frame4(30, 1);
    compare_windows("postrst", 1'b0);

    // Default 16x16 random frame with random gaps
    got16.delete();
    fd_cnt = 0;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        img[r][c] = pixel_t'($urandom_range(0, 255));
    build_expected(16, 16);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin
        gap = ($urandom_range(0, 3) == 0 && !(r == 15 && c == 15)) ? 1 : 0;
        send(1'b1, (r == 0 && c == 0), img[r][c], gap);
      end
`ifdef SOBEL_WIN_FRAME_DONE_EN
    check("rand_frame_done_pulse", 72'(bus16.frame_done), 72'(1));
`endif
    repeat (4) tick();
    check("rand_pulses_196", 72'(got16.size()), 72'(196));
    compare_windows("rand", 1'b1);
    check("rand_busy_after", 72'(bus16.busy), 72'(0));
`ifdef SOBEL_WIN_FRAME_DONE_EN
    check("rand_frame_done_count", 72'(fd_cnt), 72'(1));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sobel_window_gen.md
SOBEL_WINDOW_GEN -- requirements
Module: sobel_window_gen

Interface
REQ-001 SHALL have parameters: IMG_WIDTH, default 16, pixels per row (min 3); IMG_HEIGHT, default 16, rows per frame (min 3).
REQ-002 SHALL have one clock and an asynchronous, active-high reset: clk  input  1  rising-edge clock; rst  input  1  async reset, active-high.
REQ-003 SHALL have frame_start  input  1  one-cycle pulse that begins a new frame.
REQ-004 SHALL have pixel_valid  input  1  pixel_in is valid this cycle.
REQ-005 SHALL have pixel_in  input  8  grayscale pixel, raster order.
REQ-006 SHALL have comp_matrix  output  [2:0][2:0][7:0]  3x3 window, [row][col]; [2][2] newest pixel, [0][0] oldest (two rows up, two columns left).
REQ-007 SHALL have sobel_en  output  1  one-cycle pulse, comp_matrix holds a complete interior window.
REQ-008 SHALL have busy  output  1  high in FILL or RUN.

Function
REQ-009 SHALL implement FSM states IDLE, FILL, RUN, DONE.
REQ-010 IDLE: ignore pixel_valid; frame_start -> FILL, clear row/col counters.
REQ-011 A pixel SHALL be accepted when pixel_valid=1 in FILL or RUN, or in the same cycle as frame_start from any state; a pixel coinciding with frame_start SHALL be pixel (row 0, col 0) of the new frame.
REQ-012 On accept, col SHALL increment; at col=IMG_WIDTH-1 col SHALL wrap to 0 and row increment.
REQ-013 FILL -> RUN on acceptance of the last pixel of row 1; RUN -> DONE on acceptance of (IMG_HEIGHT-1, IMG_WIDTH-1); DONE -> IDLE after one cycle.
REQ-014 frame_start in FILL, RUN or DONE SHALL restart the frame: counters cleared, state FILL; line-buffer contents are not cleared.
REQ-015 On accept at column c, the window SHALL shift: col0<-col1, col1<-col2, new col2 = {lb_old[c], lb_prev[c], pixel_in} for rows 0,1,2; then lb_old[c]<-lb_prev[c], lb_prev[c]<-pixel_in.
REQ-016 comp_matrix SHALL be registered and update one cycle after acceptance; it holds its value between acceptances.
REQ-017 sobel_en SHALL pulse high for exactly one cycle, one cycle after accepting a pixel with row>=2 and col>=2, coincident with the corresponding comp_matrix update.
REQ-018 A frame SHALL produce exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2) sobel_en pulses; windows spanning a row wrap SHALL never raise sobel_en.
REQ-019 Gaps in pixel_valid SHALL stall all state without dropping or duplicating windows.
REQ-020 All pixel data SHALL be unsigned 8-bit; no arithmetic on pixel values.

Reset
REQ-021 rst SHALL force: state IDLE, row=col=0, comp_matrix=0, sobel_en=0, busy=0, immediately and asynchronously.
REQ-022 Line-buffer storage SHALL NOT require reset; its contents SHALL never reach comp_matrix before being rewritten in the current frame, except as covered by REQ-014.
REQ-023 Reset mid-frame SHALL abandon the frame; the next frame SHALL start only on frame_start.

Configuration
REQ-024 With SOBEL_WIN_FRAME_DONE_EN defined, the module SHALL add output frame_done (1 bit): a one-cycle pulse in state DONE, reset value 0.
REQ-025 Without SOBEL_WIN_FRAME_DONE_EN, the frame_done port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-026 Package sobel_pkg SHALL hold PIX_W=8, typedef pixel_t (8-bit), typedef window_t ([2:0][2:0] pixel_t), and the FSM state enum.
REQ-027 Line buffers SHALL be one sub-module, sobel_line_buffer (two rows of IMG_WIDTH pixels, one read and one write per column index per cycle), instantiated once.

Verification
REQ-028 IMG_WIDTH=4, IMG_HEIGHT=4; pixel value = row*4+col, continuous valid -> 4 sobel_en pulses; first window rows {0,1,2},{4,5,6},{8,9,10}.
REQ-029 Same frame with pixel_valid toggled every other cycle -> identical 4 windows in order; no extra pulses.
REQ-030 frame_start while pixel_valid=1 in RUN -> that pixel becomes (0,0); no sobel_en until the new frame's row 2, col 2.
REQ-031 rst asserted after the 7th pixel -> comp_matrix=0, sobel_en=0, busy=0 in the same cycle; pixel_valid ignored until frame_start.
REQ-032 Default 16x16 frame, random pixels -> exactly 196 sobel_en pulses, each window matching a reference model; with SOBEL_WIN_FRAME_DONE_EN, frame_done pulses once, one cycle after the last acceptance.
